cpu_trace_parser: RTL

CPU_TRACE_PARSER -- requirements
Module: cpu_trace_parser

---
 rtl/cpu_trace_parser.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_parser.sv
// Streaming parser for CPU trace lines such as "^12@00003000: $5 <= 0000000a#".
// One character is consumed per clock. Decoded fields and semantic flags are published when '#' is accepted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for '^' to start a line
// TIME     | collecting decimal time digits, '@' ends the field
// PC       | collecting exactly HEX_DIGITS pc digits, ':' ends the field
// COLON_SP | spaces after ':', then '$' (register) or '*' (memory)
// GRF      | collecting decimal register number
// ADDR     | collecting exactly HEX_DIGITS address digits
// DST_SP   | spaces after the destination, waiting for '<'
// LT       | '<' seen, expecting '='
// EQ_SP    | spaces after "<=", first data digit leaves
// DATA     | collecting exactly HEX_DIGITS data digits, '#' ends the line
// DONE     | one-cycle result strobe on format_type
module cpu_trace_parser #(
    parameter int          TIME_DIGITS_MAX = 4,
    parameter int          GRF_DIGITS_MAX  = 4,
    parameter int          HEX_DIGITS      = 8,
    parameter logic [31:0] PC_LO           = 32'h0000_3000,
    parameter logic [31:0] PC_HI           = 32'h0000_6ffc,
    parameter int          CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    output logic [1:0]       format_type,
    output logic [2:0]       sem_err,
    output logic [31:0]      time_val,
    output logic [31:0]      pc_val,
    output logic [31:0]      dst_val,
    output logic [31:0]      data_val,
    output logic [CNT_W-1:0] line_cnt
);

    typedef enum logic [3:0] {
        IDLE,
        TIME,
        PC,
        COLON_SP,
        GRF,
        ADDR,
        DST_SP,
        LT,
        EQ_SP,
        DATA,
        DONE
    } state_t;

    localparam logic [7:0] CH_CARET = 8'h5e;
    localparam logic [7:0] CH_AT    = 8'h40;
    localparam logic [7:0] CH_COLON = 8'h3a;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DOLL  = 8'h24;
    localparam logic [7:0] CH_STAR  = 8'h2a;
    localparam logic [7:0] CH_LT    = 8'h3c;
    localparam logic [7:0] CH_EQ    = 8'h3d;
    localparam logic [7:0] CH_HASH  = 8'h23;

    localparam logic [7:0] TIME_MAX = 8'(TIME_DIGITS_MAX);
    localparam logic [7:0] GRF_MAX  = 8'(GRF_DIGITS_MAX);
    localparam logic [7:0] HEX_LEN  = 8'(HEX_DIGITS);

    localparam logic [CNT_W-1:0] CNT_FULL = '1;

    state_t      state;
    logic [7:0]  digit_cnt;
    logic [31:0] time_sh;
    logic [31:0] pc_sh;
    logic [31:0] dst_sh;
    logic [31:0] data_sh;
    logic        is_reg;

    logic        is_dec;
    logic        is_hex;
    logic [3:0]  nib;
    logic [31:0] time_dec_next;
    logic [31:0] dst_dec_next;
    logic [31:0] pc_hex_next;
    logic [31:0] dst_hex_next;
    logic [31:0] data_hex_next;
    logic [2:0]  sem_next;
    logic [1:0]  fmt_next;

    // Lowercase a-f only; their low nibble is 1..6, so +9 yields 10..15.
    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
        nib    = is_dec ? char[3:0] : (char[3:0] + 4'd9);
    end

    always_comb begin
        time_dec_next = (time_sh * 32'd10) + {28'd0, nib};
        dst_dec_next  = (dst_sh * 32'd10) + {28'd0, nib};
        pc_hex_next   = {pc_sh[27:0], nib};
        dst_hex_next  = {dst_sh[27:0], nib};
        data_hex_next = {data_sh[27:0], nib};
    end

    // Shadow registers are final when '#' is sampled, so the flags are ready on that edge.
    always_comb begin
        sem_next    = 3'b000;
        sem_next[0] = (pc_sh < PC_LO) || (pc_sh > PC_HI);
        sem_next[1] = (pc_sh[1:0] != 2'b00) || (!is_reg && (dst_sh[1:0] != 2'b00));
        sem_next[2] = is_reg && (dst_sh > 32'd31);
        if (sem_next != 3'b000) begin
            fmt_next = 2'b11;
        end else if (is_reg) begin
            fmt_next = 2'b01;
        end else begin
            fmt_next = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            digit_cnt   <= 8'd0;
            time_sh     <= 32'd0;
            pc_sh       <= 32'd0;
            dst_sh      <= 32'd0;
            data_sh     <= 32'd0;
            is_reg      <= 1'b0;
            format_type <= 2'b00;
            sem_err     <= 3'b000;
            time_val    <= 32'd0;
            pc_val      <= 32'd0;
            dst_val     <= 32'd0;
            data_val    <= 32'd0;
            line_cnt    <= '0;
        end else begin
            format_type <= 2'b00;
            if (char == CH_CARET) begin
                state     <= TIME;
                digit_cnt <= 8'd0;
                time_sh   <= 32'd0;
                pc_sh     <= 32'd0;
                dst_sh    <= 32'd0;
                data_sh   <= 32'd0;
                is_reg    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    TIME: begin
                        if (is_dec && (digit_cnt < TIME_MAX)) begin
                            time_sh   <= time_dec_next;
                            digit_cnt <= digit_cnt + 8'd1;
                        end else if ((char == CH_AT) && (digit_cnt != 8'd0)) begin
                            state     <= PC;
                            digit_cnt <= 8'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PC: begin
                        if (is_hex && (digit_cnt < HEX_LEN)) begin
                            pc_sh     <= pc_hex_next;
                            digit_cnt <= digit_cnt + 8'd1;
                        end else if ((char == CH_COLON) && (digit_cnt == HEX_LEN)) begin
                            state <= COLON_SP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    COLON_SP: begin
                        digit_cnt <= 8'd0;
                        if (char == CH_SPACE) begin
                            state <= COLON_SP;
                        end else if (char == CH_DOLL) begin
                            state  <= GRF;
                            is_reg <= 1'b1;
                        end else if (char == CH_STAR) begin
                            state  <= ADDR;
                            is_reg <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    GRF: begin
                        if (is_dec && (digit_cnt < GRF_MAX)) begin
                            dst_sh    <= dst_dec_next;
                            digit_cnt <= digit_cnt + 8'd1;
                        end else if ((char == CH_SPACE) && (digit_cnt != 8'd0)) begin
                            state <= DST_SP;
                        end else if ((char == CH_LT) && (digit_cnt != 8'd0)) begin
                            state <= LT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    ADDR: begin
                        if (is_hex && (digit_cnt < HEX_LEN)) begin
                            dst_sh    <= dst_hex_next;
                            digit_cnt <= digit_cnt + 8'd1;
                        end else if ((char == CH_SPACE) && (digit_cnt == HEX_LEN)) begin
                            state <= DST_SP;
                        end else if ((char == CH_LT) && (digit_cnt == HEX_LEN)) begin
                            state <= LT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DST_SP: begin
                        if (char == CH_SPACE) begin
                            state <= DST_SP;
                        end else if (char == CH_LT) begin
                            state <= LT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    LT: begin
                        state     <= (char == CH_EQ) ? EQ_SP : IDLE;
                        digit_cnt <= 8'd0;
                    end
                    EQ_SP: begin
                        if (char == CH_SPACE) begin
                            state <= EQ_SP;
                        end else if (is_hex) begin
                            state     <= DATA;
                            data_sh   <= data_hex_next;
                            digit_cnt <= 8'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DATA: begin
                        if (is_hex && (digit_cnt < HEX_LEN)) begin
                            data_sh   <= data_hex_next;
                            digit_cnt <= digit_cnt + 8'd1;
                        end else if ((char == CH_HASH) && (digit_cnt == HEX_LEN)) begin
                            state       <= DONE;
                            format_type <= fmt_next;
                            sem_err     <= sem_next;
                            time_val    <= time_sh;
                            pc_val      <= pc_sh;
                            dst_val     <= dst_sh;
                            data_val    <= data_sh;
                            if ((fmt_next != 2'b11) && (line_cnt != CNT_FULL)) begin
                                line_cnt <= line_cnt + 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
